mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multicycle memory access sequencer for the MIPS datapath.
- Sits directly downstream of the memory-address mux and consumes its 32-bit selected address (PC, ALUOut, exception vectors 253/254/255, RD).
- Drives the word-wide synchronous RAM, performs load extension and store read-modify-write for byte/halfword ops, and returns the load word to MDR.
- The control unit starts an access with a one-cycle pulse and waits for done.

Parameters:
- RD_LAT, 1, cycles from mem_addr valid to mem_rdata valid (legal 1..4).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request pulse from control unit
- op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- addr  in  32  byte address from memory-address mux
- wdata  in  32  store data (register B)
- busy  out  1  high from cycle after start until done cycle inclusive
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result to MDR
- addr_err  out  1  misaligned access flag, valid with done
- mem_addr  out  32  word address to RAM, {addr[31:2],2'b00}
- mem_wr  out  1  RAM write strobe
- mem_wdata  out  32  RAM write word
- mem_rdata  in  32  RAM read word

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, mem_wr, addr_err = 0; rdata, mem_addr, mem_wdata = 0. Reset mid-operation aborts immediately with no write issued after the reset edge.
- On start in IDLE: latch op, addr, wdata. Start while busy is ignored; latched values hold for the whole access.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0. Halfword lane is selected by addr[1]; 0 selects bits 15:0.
- FSM states: IDLE, RD, WR, DONE.
  - Loads: IDLE -> RD for RD_LAT cycles -> DONE. rdata captured on the last RD cycle.
  - SW: IDLE -> WR -> DONE.
  - SH/SB: IDLE -> RD (RD_LAT cycles) -> WR -> DONE.
  - DONE -> IDLE.
- RD: mem_addr driven, mem_wr=0, a counter counts RD_LAT cycles.
- WR: mem_wr=1 for exactly one cycle.
  - SW: mem_wdata = wdata.
  - SH/SB: mem_wdata = the read word with only the target lane replaced by wdata[15:0] or wdata[7:0].
- Latency, start sampled at edge 0:
  - loads: done at cycle RD_LAT+1
  - SW: done at cycle 2
  - SH/SB: done at cycle RD_LAT+2
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- rdata updates only on load completion and holds between accesses; stores leave it unchanged.
- done is high only in DONE. A start in that same cycle is ignored; the next start is accepted in IDLE.
- mem_addr holds its last value in IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - A misaligned access skips RD/WR and goes IDLE -> DONE, so done is at cycle 1.
  - addr_err=1 during that done cycle only; mem_wr is never asserted and rdata is unchanged.
- Undefined:
  - addr_err tied 0.
  - Word ops ignore addr[1:0]; halfword ops ignore addr[0].

Test Plan:
- Reset mid-access: start SB to 0x10, assert reset in the RD cycle -> all outputs 0 asynchronously, RAM word unchanged, start after release is accepted normally.
- LW, RD_LAT=2: RAM[0x40]=0x8A7B6C5D, start LW addr=0x40 -> done at cycle 3, rdata=0x8A7B6C5D, mem_wr never high.
- LB vs LBU at addr 0x43, same word:
  - LB -> rdata=0xFFFFFF8A.
  - LBU -> rdata=0x0000008A.
  - LH at 0x42 -> rdata=0xFFFF8A7B.
- SB 0xEE to 0x41, RAM word 0x11223344 -> one mem_wr pulse with mem_wdata=0x1122EE44, done at RD_LAT+2.
- SW 0xCAFEBABE to 0x100 -> mem_wr at cycle 1, done at cycle 2. A second start issued at cycle 1 is ignored (single write observed).
- MEM_ALIGN_CHECK_EN defined, LW addr=0x102:
  - done at cycle 1 with addr_err=1, no mem_wr, rdata holds its previous value.
  - Macro undefined: the same access reads word 0x100 with addr_err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle RAM access sequencer with load extension and sub-word read-modify-write.
// Optional MEM_ALIGN_CHECK_EN flags misaligned word/halfword accesses and completes them without touching RAM.
module mem_access_ctrl #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   localparam logic [1:0] LAST = 2'(RD_LAT - 1);
   state_t state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [1:0] off_q, off_d, cnt_q, cnt_d;
   logic [15:0] wd_q, wd_d;
   logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic mis_q, mis_d, mis_in, is_ld;
   logic [7:0] lb;
   logic [15:0] lh;
   logic [31:0] ext, merged;
`ifdef MEM_ALIGN_CHECK_EN
   assign mis_in = ((op == 3'b000 || op == 3'b101) && addr[1:0] != 2'b00) ||
                   ((op == 3'b001 || op == 3'b010 || op == 3'b110) && addr[0]);
`else
   assign mis_in = 1'b0;
`endif
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign mem_wr    = state_q == WR;
   assign addr_err  = done && mis_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign is_ld     = !op_q[2] || op_q == 3'b100;
   always_comb begin
      lb = mem_rdata[{off_q, 3'b000} +: 8];
      lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ext = op_q == 3'b001 ? {{16{lh[15]}}, lh} :
            op_q == 3'b010 ? {16'h0, lh} :
            op_q == 3'b011 ? {{24{lb[7]}}, lb} :
            op_q == 3'b100 ? {24'h0, lb} : mem_rdata;
      merged = mem_rdata;
      if (op_q == 3'b111) merged[{off_q, 3'b000} +: 8] = wd_q[7:0];
      else merged[{off_q[1], 4'b0000} +: 16] = wd_q;
      state_d     = state_q;
      op_d        = op_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      wd_d        = wd_q;
      mis_d       = mis_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: if (start) begin
            op_d        = op;
            off_d       = addr[1:0];
            wd_d        = wdata[15:0];
            mis_d       = mis_in;
            cnt_d       = 2'd0;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = (op == 3'b101 && !mis_in) ? wdata : mem_wdata_q;
            state_d     = mis_in ? DONE : op == 3'b101 ? WR : RD;
         end
         RD: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST) begin
               state_d     = is_ld ? DONE : WR;
               rdata_d     = is_ld ? ext : rdata_q;
               mem_wdata_d = is_ld ? mem_wdata_q : merged;
            end
         end
         WR:      state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= 3'b000;
         off_q       <= 2'b00;
         cnt_q       <= 2'd0;
         wd_q        <= 16'h0;
         mis_q       <= 1'b0;
         rdata_q     <= 32'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         wd_q        <= wd_d;
         mis_q       <= mis_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a two-cycle-latency word RAM.
module tb_mem_access_ctrl;
   localparam int unsigned LAT = 2;
   logic clock = 1'b0, reset = 1'b0, start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic busy, done, addr_err, mem_wr;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] ram [0:255];
   logic [31:0] rd_p = 32'h0;
   logic pk = 1'b0;
   logic [7:0] pk_i = 8'h0;
   logic [31:0] pk_v = 32'h0;
   int wr_cnt = 0;
   int tests = 0, fails = 0;

   mem_access_ctrl #(.RD_LAT(LAT)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err), .mem_addr(mem_addr),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;
   assign mem_rdata = rd_p;

   always @(posedge clock) begin
      rd_p <= ram[mem_addr[9:2]];
      if (pk) ram[pk_i] <= pk_v;
      if (mem_wr) begin
         ram[mem_addr[9:2]] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic poke(input logic [7:0] i, input logic [31:0] v);
      pk = 1'b1; pk_i = i; pk_v = v;
      @(posedge clock); #1;
      pk = 1'b0;
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input bit again,
                      output int lat, output int wrs, output int wcyc, output logic [31:0] wd,
                      output logic err);
      int w0;
      w0 = wr_cnt; lat = -1; wcyc = -1; wd = 32'h0; err = 1'b0;
      op = o; addr = a; wdata = w; start = 1'b1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clock); #1;
         start = again && n == 1;
         if (start) wdata = 32'h0;
         if (mem_wr) begin wcyc = n; wd = mem_wdata; end
         if (done) begin lat = n; err = addr_err; end
      end
      start = 1'b0;
      @(posedge clock); #1;
      wrs = wr_cnt - w0;
   endtask

   task automatic test_reset;
      int lat, wrs, wcyc;
      logic [31:0] wd;
      logic err, all0;
      #1;
      all0 = !busy && !done && !mem_wr && !addr_err && rdata == 0 && mem_addr == 0 && mem_wdata == 0;
      tests++; if (all0 !== 1'b1) begin fails++; $display("FAIL reset_init outputs busy=%b done=%b rdata=%h mem_addr=%h exp all zero", busy, done, rdata, mem_addr); end
      @(posedge clock); #1; reset = 1'b1;
      poke(8'd4, 32'hA5A5A5A5);
      op = 3'b111; addr = 32'h10; wdata = 32'h77; start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      tests++; if (busy !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL reset_mid_started busy=%b mem_addr=%h exp 1 00000010", busy, mem_addr); end
      reset = 1'b0; #1;
      all0 = !busy && !done && !mem_wr && !addr_err && rdata == 0 && mem_addr == 0 && mem_wdata == 0;
      tests++; if (all0 !== 1'b1) begin fails++; $display("FAIL reset_async outputs busy=%b mem_addr=%h mem_wdata=%h exp all zero", busy, mem_addr, mem_wdata); end
      @(posedge clock); #1; reset = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      tests++; if (ram[4] !== 32'hA5A5A5A5 || wr_cnt !== 0) begin fails++; $display("FAIL reset_no_write ram=%h writes=%0d exp a5a5a5a5 0", ram[4], wr_cnt); end
      run(3'b000, 32'h10, 32'h0, 1'b0, lat, wrs, wcyc, wd, err);
      tests++; if (lat !== 3 || rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL reset_after_lw lat=%0d rdata=%h exp 3 a5a5a5a5", lat, rdata); end
   endtask

   task automatic test_lw;
      int lat, wrs, wcyc;
      logic [31:0] wd;
      logic err;
      poke(8'd16, 32'h8A7B6C5D);
      run(3'b000, 32'h40, 32'h0, 1'b0, lat, wrs, wcyc, wd, err);
      tests++; if (lat !== 3) begin fails++; $display("FAIL lw_latency got %0d exp 3", lat); end
      tests++; if (rdata !== 32'h8A7B6C5D) begin fails++; $display("FAIL lw_rdata got %h exp 8a7b6c5d", rdata); end
      tests++; if (wrs !== 0 || err !== 1'b0) begin fails++; $display("FAIL lw_nowrite writes=%0d err=%b exp 0 0", wrs, err); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lw_idle busy=%b exp 0", busy); end
   endtask

   task automatic test_ext;
      logic [2:0] ops [6] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b001, 3'b011};
      logic [31:0] as [6] = '{32'h43, 32'h43, 32'h42, 32'h40, 32'h40, 32'h40};
      logic [31:0] ex [6] = '{32'hFFFFFF8A, 32'h0000008A, 32'hFFFF8A7B, 32'h00006C5D, 32'h00006C5D, 32'h0000005D};
      int lat, wrs, wcyc;
      logic [31:0] wd;
      logic err;
      for (int i = 0; i < 6; i++) begin
         run(ops[i], as[i], 32'h0, 1'b0, lat, wrs, wcyc, wd, err);
         tests++; if (rdata !== ex[i] || lat !== 3) begin fails++; $display("FAIL ext_%0d op=%b rdata=%h lat=%0d exp %h 3", i, ops[i], rdata, lat, ex[i]); end
      end
   endtask

   task automatic test_subword_store;
      int lat, wrs, wcyc;
      logic [31:0] wd;
      logic err;
      poke(8'd16, 32'h11223344);
      run(3'b111, 32'h41, 32'hFFFFFFEE, 1'b0, lat, wrs, wcyc, wd, err);
      tests++; if (lat !== 4 || wcyc !== 3) begin fails++; $display("FAIL sb_timing lat=%0d wrcyc=%0d exp 4 3", lat, wcyc); end
      tests++; if (wrs !== 1 || wd !== 32'h1122EE44) begin fails++; $display("FAIL sb_write writes=%0d wdata=%h exp 1 1122ee44", wrs, wd); end
      tests++; if (ram[16] !== 32'h1122EE44 || rdata !== 32'h0000005D) begin fails++; $display("FAIL sb_ram ram=%h rdata=%h exp 1122ee44 0000005d", ram[16], rdata); end
      run(3'b110, 32'h42, 32'h1234BEEF, 1'b0, lat, wrs, wcyc, wd, err);
      tests++; if (lat !== 4 || wrs !== 1 || wd !== 32'hBEEFEE44) begin fails++; $display("FAIL sh_write lat=%0d writes=%0d wdata=%h exp 4 1 beefee44", lat, wrs, wd); end
   endtask

   task automatic test_back_to_back;
      int lat, wrs, wcyc, w1;
      logic [31:0] wd;
      logic err;
      run(3'b101, 32'h100, 32'hCAFEBABE, 1'b1, lat, wrs, wcyc, wd, err);
      tests++; if (wcyc !== 1 || lat !== 2) begin fails++; $display("FAIL sw_timing wrcyc=%0d lat=%0d exp 1 2", wcyc, lat); end
      tests++; if (wd !== 32'hCAFEBABE || ram[64] !== 32'hCAFEBABE) begin fails++; $display("FAIL sw_data wdata=%h ram=%h exp cafebabe", wd, ram[64]); end
      w1 = wr_cnt;
      repeat (4) @(posedge clock);
      #1;
      tests++; if (wrs !== 1 || wr_cnt !== w1 || busy !== 1'b0) begin fails++; $display("FAIL sw_ignored_start writes=%0d extra=%0d busy=%b exp 1 0 0", wrs, wr_cnt - w1, busy); end
   endtask

   task automatic test_align;
      int lat, wrs, wcyc;
      logic [31:0] wd;
      logic err;
      run(3'b000, 32'h102, 32'h0, 1'b0, lat, wrs, wcyc, wd, err);
`ifdef MEM_ALIGN_CHECK_EN
      tests++; if (lat !== 1 || err !== 1'b1) begin fails++; $display("FAIL align_err lat=%0d addr_err=%b exp 1 1", lat, err); end
      tests++; if (wrs !== 0 || rdata !== 32'h0000005D) begin fails++; $display("FAIL align_hold writes=%0d rdata=%h exp 0 0000005d", wrs, rdata); end
`else
      tests++; if (lat !== 3 || err !== 1'b0) begin fails++; $display("FAIL align_off lat=%0d addr_err=%b exp 3 0", lat, err); end
      tests++; if (wrs !== 0 || rdata !== 32'hCAFEBABE) begin fails++; $display("FAIL align_off_data writes=%0d rdata=%h exp 0 cafebabe", wrs, rdata); end
`endif
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL align_clear addr_err=%b exp 0", addr_err); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      test_reset;
      test_lw;
      test_ext;
      test_subword_store;
      test_back_to_back;
      test_align;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
